// File: rtl/decoder_pkg.sv
// Shared widths and constants for the 5-to-32 decoder slice.
// Optional macro DECODER_COMB_OUT_EN is consumed by decoder_5to32_if and decoder_5to32.
package decoder_pkg;

   localparam int unsigned DEC_IN_W   = 5;
   localparam int unsigned DEC_OUT_W  = 32;
   localparam int unsigned DEC_BANK_W = 8;

   localparam logic [DEC_OUT_W-1:0] DEC_NONE = 32'h0;

   // Bank select for the upper two index bits.
   function automatic logic [3:0] predecode_2to4(input logic [1:0] sel);
      logic [3:0] onehot;
      onehot = 4'b0001 << sel;
      return onehot;
   endfunction

endpackage

// File: rtl/decoder_5to32_if.sv
// Select/enable request and registered one-hot response of decoder_5to32.
// Macro DECODER_COMB_OUT_EN adds the unregistered decode D_COMB.
interface decoder_5to32_if
   import decoder_pkg::*;
();

   logic                 EN;
   logic [DEC_IN_W-1:0]  I;
   logic [DEC_OUT_W-1:0] D;
   logic                 VALID;
`ifdef DECODER_COMB_OUT_EN
   logic [DEC_OUT_W-1:0] D_COMB;
`endif

`ifdef DECODER_COMB_OUT_EN
   modport master (output EN, output I, input D, input VALID, input D_COMB);
   modport slave  (input EN, input I, output D, output VALID, output D_COMB);
`else
   modport master (output EN, output I, input D, input VALID);
   modport slave  (input EN, input I, output D, output VALID);
`endif

endinterface

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all lines low when G=0.
module decoder_3to8
   import decoder_pkg::*;
(
   input  logic [2:0]            I,
   input  logic                  G,
   output logic [DEC_BANK_W-1:0] D
);

   always_comb begin
      D = '0;
      if (G) begin
         D = 8'b0000_0001 << I;
      end
   end

endmodule

// File: rtl/decoder_5to32.sv
// Registered 5-to-32 one-hot decoder: 2-to-4 bank predecode feeding four gated 3-to8 decoders.
// Macro DECODER_COMB_OUT_EN exposes the unregistered decode on D_COMB.
module decoder_5to32
   import decoder_pkg::*;
#(
   parameter int unsigned IN_WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   decoder_5to32_if.slave   bus
);

   localparam int unsigned OUT_WIDTH = 1 << IN_WIDTH;

   if (IN_WIDTH != DEC_IN_W) begin : g_width_check
      $error("decoder_5to32 supports IN_WIDTH=5 only");
   end

   logic [3:0]           bank_sel;
   logic [OUT_WIDTH-1:0] dec_comb;
   logic [OUT_WIDTH-1:0] d_q;
   logic                 valid_q;

   // EN is folded into the bank select so every sub-decoder is gated by it.
   always_comb begin
      bank_sel = 4'b0000;
      if (bus.EN) begin
         bank_sel = predecode_2to4(bus.I[4:3]);
      end
   end

   for (genvar b = 0; b < 4; b++) begin : g_bank
      decoder_3to8 u_dec (
         .I (bus.I[2:0]),
         .G (bank_sel[b]),
         .D (dec_comb[b*DEC_BANK_W +: DEC_BANK_W])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         d_q     <= DEC_NONE;
         valid_q <= 1'b0;
      end else begin
         d_q     <= dec_comb;
         valid_q <= bus.EN;
      end
   end

   assign bus.D     = d_q;
   assign bus.VALID = valid_q;

`ifdef DECODER_COMB_OUT_EN
   assign bus.D_COMB = dec_comb;
`endif

endmodule

// File: tb/tb_decoder_5to32.sv
// Scoreboard bench for decoder_5to32: driver queues expected results, monitor pops and compares.
module tb_decoder_5to32;

   typedef struct {
      logic [31:0] d;
      logic        v;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t cur;

   always #5 clk = ~clk;

   decoder_5to32_if bus ();

   decoder_5to32 u_dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Drive one cycle of stimulus on the falling edge and queue its expected result.
   task automatic step(input logic r, input logic e, input logic [4:0] idx,
                       input logic [31:0] exp_d, input logic exp_v, input string nm);
      exp_t item;
      @(negedge clk);
      rst    = r;
      bus.EN = e;
      bus.I  = idx;
      item.d = exp_d;
      item.v = exp_v;
      item.name = nm;
      sb.push_back(item);
   endtask

   // Monitor: one registered result per rising edge once stimulus has started.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         cur = sb.pop_front();
         checks++;
         if (bus.D !== cur.d || bus.VALID !== cur.v) begin
            errors++;
            $display("FAIL %s: got D=%h VALID=%b, expected D=%h VALID=%b",
                     cur.name, bus.D, bus.VALID, cur.d, cur.v);
         end
         checks++;
         if (bus.VALID === 1'b1 ? ($countones(bus.D) != 1) : (bus.D !== 32'h0)) begin
            errors++;
            $display("FAIL onehot_invariant (%s): got D=%h VALID=%b", cur.name, bus.D, bus.VALID);
         end
      end
   end

   initial begin
      logic [5:0] wide;
      rst    = 1'b0;
      bus.EN = 1'b1;
      bus.I  = 5'd5;

      // Reset overrides EN, then release.
      step(1'b0, 1'b1, 5'd5, 32'h0000_0000, 1'b0, "reset_0");
      step(1'b0, 1'b1, 5'd5, 32'h0000_0000, 1'b0, "reset_1");
      step(1'b1, 1'b1, 5'd5, 32'h0000_0020, 1'b1, "reset_release");

      // Sweep every index, one per cycle.
      for (int k = 0; k < 32; k++) begin
         step(1'b1, 1'b1, k[4:0], 32'h1 << k, 1'b1, $sformatf("sweep_%0d", k));
      end
      step(1'b1, 1'b1, 5'd16, 32'h0001_0000, 1'b1, "idx16");
      step(1'b1, 1'b1, 5'd31, 32'h8000_0000, 1'b1, "idx31");
      step(1'b1, 1'b1, 5'd0,  32'h0000_0001, 1'b1, "idx0");

      // Wider source truncated to the port width.
      wide = 6'b100000;
      step(1'b1, 1'b1, wide[4:0], 32'h0000_0001, 1'b1, "truncate");

      // Enable gating does not hold the previous value.
      step(1'b1, 1'b1, 5'd7, 32'h0000_0080, 1'b1, "en_on_0");
      step(1'b1, 1'b0, 5'd7, 32'h0000_0000, 1'b0, "en_off");
      step(1'b1, 1'b1, 5'd7, 32'h0000_0080, 1'b1, "en_on_1");

      // Mid-stream reset.
      step(1'b1, 1'b1, 5'd3, 32'h0000_0008, 1'b1, "mid_pre");
      step(1'b0, 1'b1, 5'd3, 32'h0000_0000, 1'b0, "mid_reset");
      step(1'b1, 1'b1, 5'd3, 32'h0000_0008, 1'b1, "mid_release");

`ifdef DECODER_COMB_OUT_EN
      step(1'b1, 1'b1, 5'd12, 32'h0000_1000, 1'b1, "comb_reg");
      #1;
      checks++;
      if (bus.D_COMB !== 32'h0000_1000) begin
         errors++;
         $display("FAIL comb_en: got D_COMB=%h, expected 00001000", bus.D_COMB);
      end
      step(1'b0, 1'b0, 5'd12, 32'h0000_0000, 1'b0, "comb_off_reg");
      #1;
      checks++;
      if (bus.D_COMB !== 32'h0000_0000) begin
         errors++;
         $display("FAIL comb_dis: got D_COMB=%h, expected 00000000", bus.D_COMB);
      end
`endif

      // Drain the scoreboard with a bounded wait.
      for (int n = 0; n < 5 && sb.size() > 0; n++) begin
         @(posedge clk);
         #2;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
